// File: rtl/rf_access_ctrl.sv
// Access controller for a 16 x 16-bit register file: decodes pipeline reads/writes into one-hot
// strobes and arbitrates write port and read port 2 with a debug requester (starvation-bounded).
module rf_access_ctrl #(
  parameter int unsigned NREG         = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  // pipeline side
  input  logic            pipe_re1,
  input  logic            pipe_re2,
  input  logic [3:0]      pipe_ra1,
  input  logic [3:0]      pipe_ra2,
  input  logic            pipe_we,
  input  logic [3:0]      pipe_wa,
  input  logic [15:0]     pipe_wd,
  input  logic [1:0]      pipe_wmode,
  output logic            pipe_stall,
  // debug side
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [3:0]      dbg_addr,
  input  logic [15:0]     dbg_wd,
  output logic            dbg_gnt,
  output logic [15:0]     dbg_rdata,
  output logic            dbg_rvalid,
  // register file side
  output logic [NREG-1:0] rf_re1,
  output logic [NREG-1:0] rf_re2,
  output logic [NREG-1:0] rf_we,
  output logic [15:0]     rf_wd,
  output logic [15:0]     rf_bytesel,
  input  logic [15:0]     rf_bl2
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StForce = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dbg_rdata_q;
  logic        dbg_rvalid_q;

  logic        force_st;
  logic        dbg_ok;
  logic        gnt;
  logic        dbg_rd_gnt;
  logic        dbg_wr_gnt;
  logic        do_wr;
  logic [3:0]  wa;

  function automatic logic [NREG-1:0] onehot(input logic [3:0] a);
    logic [NREG-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Grant evaluation: debug write needs the write port, debug read needs read port 2.
  always_comb begin
    force_st   = (state_q == StForce);
    dbg_ok     = dbg_we ? !pipe_we : !pipe_re2;
    gnt        = rst && dbg_req && (dbg_ok || force_st);
    dbg_rd_gnt = gnt && !dbg_we;
    dbg_wr_gnt = gnt && dbg_we;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (dbg_req && !dbg_ok) begin
          cnt_d   = 4'd1;
          state_d = (cnt_d >= Limit) ? StForce : StWait;
        end
      end
      StWait: begin
        if (!dbg_req || dbg_ok) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d >= Limit) begin
            state_d = StForce;
          end
        end
      end
      StForce: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Strobe decode; the debug access, when granted, displaces only the pipeline port it needs.
  always_comb begin
    rf_re1     = '0;
    rf_re2     = '0;
    rf_we      = '0;
    rf_wd      = '0;
    rf_bytesel = '0;
    do_wr      = 1'b0;
    wa         = pipe_wa;
    if (rst) begin
      if (pipe_re1) begin
        rf_re1 = onehot(pipe_ra1);
      end
      if (dbg_rd_gnt) begin
        rf_re2 = onehot(dbg_addr);
      end else if (pipe_re2) begin
        rf_re2 = onehot(pipe_ra2);
      end
      if (dbg_wr_gnt) begin
        do_wr      = 1'b1;
        wa         = dbg_addr;
        rf_wd      = dbg_wd;
        rf_bytesel = 16'hFFFF;
      end else begin
        do_wr = pipe_we;
        rf_wd = pipe_wd;
        unique case (pipe_wmode)
          2'd1:    rf_bytesel = 16'h00FF;
          2'd2:    rf_bytesel = 16'hFF00;
          default: rf_bytesel = 16'hFFFF;
        endcase
      end
      // R0 is hard-wired to zero, so its write enable never fires.
      if (do_wr && (wa != 4'd0)) begin
        rf_we = onehot(wa);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      dbg_rdata_q  <= 16'h0000;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dbg_rvalid_q <= dbg_rd_gnt;
      if (dbg_rd_gnt) begin
        dbg_rdata_q <= rf_bl2;
      end
    end
  end

  assign pipe_stall = force_st;
  assign dbg_gnt    = gnt;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl; a behavioural 16 x 16 register file closes the loop.
module tb_rf_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_re1, pipe_re2;
  logic [3:0]  pipe_ra1, pipe_ra2;
  logic        pipe_we;
  logic [3:0]  pipe_wa;
  logic [15:0] pipe_wd;
  logic [1:0]  pipe_wmode;
  logic        pipe_stall;
  logic        dbg_req, dbg_we;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_wd;
  logic        dbg_gnt;
  logic [15:0] dbg_rdata;
  logic        dbg_rvalid;
  logic [15:0] rf_re1, rf_re2, rf_we;
  logic [15:0] rf_wd, rf_bytesel;
  logic [15:0] bl1, bl2;
  logic [15:0] regs [16];

  int n_tests = 0;
  int n_fail  = 0;

  rf_access_ctrl #(.NREG(16), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_re1   (pipe_re1),
    .pipe_re2   (pipe_re2),
    .pipe_ra1   (pipe_ra1),
    .pipe_ra2   (pipe_ra2),
    .pipe_we    (pipe_we),
    .pipe_wa    (pipe_wa),
    .pipe_wd    (pipe_wd),
    .pipe_wmode (pipe_wmode),
    .pipe_stall (pipe_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wd     (dbg_wd),
    .dbg_gnt    (dbg_gnt),
    .dbg_rdata  (dbg_rdata),
    .dbg_rvalid (dbg_rvalid),
    .rf_re1     (rf_re1),
    .rf_re2     (rf_re2),
    .rf_we      (rf_we),
    .rf_wd      (rf_wd),
    .rf_bytesel (rf_bytesel),
    .rf_bl2     (bl2)
  );

  always #5 clk = ~clk;

  // Register file model: masked writes on the edge, R0 hard-wired, reads see pre-edge contents.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
    end else begin
      for (int i = 1; i < 16; i++) begin
        if (rf_we[i]) regs[i] <= (regs[i] & ~rf_bytesel) | (rf_wd & rf_bytesel);
      end
    end
  end

  always_comb begin
    bl1 = '0;
    bl2 = '0;
    for (int i = 0; i < 16; i++) begin
      if (rf_re1[i]) bl1 = bl1 | regs[i];
      if (rf_re2[i]) bl2 = bl2 | regs[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pipe_re1 = 0; pipe_re2 = 0; pipe_ra1 = 0; pipe_ra2 = 0;
    pipe_we = 0; pipe_wa = 0; pipe_wd = 0; pipe_wmode = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wd = 0;
  endtask

  task automatic pipe_write(input logic [3:0] a, input logic [15:0] d);
    clear_inputs();
    pipe_we = 1; pipe_wa = a; pipe_wd = d; pipe_wmode = 2'd0;
    tick();
  endtask

  initial begin
    // Reset with live requests: all strobes and grants must be held low.
    rst = 0;
    clear_inputs();
    pipe_we = 1; pipe_wa = 4'd5; pipe_re1 = 1; pipe_ra1 = 4'd3;
    dbg_req = 1; dbg_we = 0; dbg_addr = 4'd3;
    #2;
    chk("rst_rf_we", rf_we, 16'h0000);
    chk("rst_rf_re1", rf_re1, 16'h0000);
    chk("rst_gnt", dbg_gnt, 1'b0);
    chk("rst_stall", pipe_stall, 1'b0);
    chk("rst_rvalid", dbg_rvalid, 1'b0);
    chk("rst_rdata", dbg_rdata, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    clear_inputs();
    rst = 1;
    #1;

    // Pipeline byte write.
    pipe_write(4'd5, 16'h1111);
    pipe_we = 1; pipe_wa = 4'd5; pipe_wd = 16'hABCD; pipe_wmode = 2'd1;
    #1;
    chk("bw_we", rf_we, 16'h0020);
    chk("bw_bytesel", rf_bytesel, 16'h00FF);
    chk("bw_wd", rf_wd, 16'hABCD);
    pipe_wmode = 2'd2; #1;
    chk("bw_mode2", rf_bytesel, 16'hFF00);
    pipe_wmode = 2'd3; #1;
    chk("bw_mode3", rf_bytesel, 16'hFFFF);
    pipe_wmode = 2'd1;
    tick();
    clear_inputs();
    pipe_re1 = 1; pipe_ra1 = 4'd5;
    #1;
    chk("bw_re1", rf_re1, 16'h0020);
    chk("bw_reg5", bl1, 16'h11CD);

    // Idle debug read.
    pipe_write(4'd3, 16'h1234);
    clear_inputs();
    dbg_req = 1; dbg_we = 0; dbg_addr = 4'd3;
    #1;
    chk("rd_gnt", dbg_gnt, 1'b1);
    chk("rd_re2", rf_re2, 16'h0008);
    chk("rd_stall", pipe_stall, 1'b0);
    tick();
    clear_inputs();
    #1;
    chk("rd_rvalid", dbg_rvalid, 1'b1);
    chk("rd_rdata", dbg_rdata, 16'h1234);
    tick();
    chk("rd_rvalid_pulse", dbg_rvalid, 1'b0);
    chk("rd_rdata_hold", dbg_rdata, 16'h1234);

    // Starvation of a debug write behind a continuous pipeline write.
    clear_inputs();
    pipe_we = 1; pipe_wa = 4'd9; pipe_wd = 16'h0BAD;
    dbg_req = 1; dbg_we = 1; dbg_addr = 4'd7; dbg_wd = 16'h5A5A;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("sv_gnt_low", dbg_gnt, 1'b0);
      chk("sv_stall_low", pipe_stall, 1'b0);
      chk("sv_pipe_we", rf_we, 16'h0200);
      tick();
    end
    chk("sv_gnt_c5", dbg_gnt, 1'b1);
    chk("sv_stall_c5", pipe_stall, 1'b1);
    chk("sv_we_c5", rf_we, 16'h0080);
    chk("sv_wd_c5", rf_wd, 16'h5A5A);
    chk("sv_bytesel_c5", rf_bytesel, 16'hFFFF);
    tick();
    dbg_req = 0;
    pipe_re1 = 1; pipe_ra1 = 4'd7;
    #1;
    chk("sv_stall_c6", pipe_stall, 1'b0);
    chk("sv_reg7", bl1, 16'h5A5A);
    chk("sv_pipe_we_c6", rf_we, 16'h0200);

    // R0 protection.
    tick();
    clear_inputs();
    pipe_we = 1; pipe_wa = 4'd0; pipe_wd = 16'hFFFF;
    #1;
    chk("r0_pipe_we", rf_we, 16'h0000);
    tick();
    clear_inputs();
    dbg_req = 1; dbg_we = 1; dbg_addr = 4'd0; dbg_wd = 16'hFFFF;
    #1;
    chk("r0_dbg_gnt", dbg_gnt, 1'b1);
    chk("r0_dbg_we", rf_we, 16'h0000);
    tick();
    clear_inputs();
    pipe_re1 = 1; pipe_ra1 = 4'd0;
    #1;
    chk("r0_read", bl1, 16'h0000);

    // Same-cycle debug write and pipeline read of one register.
    pipe_write(4'd2, 16'h4444);
    clear_inputs();
    dbg_req = 1; dbg_we = 1; dbg_addr = 4'd2; dbg_wd = 16'h9999;
    pipe_re1 = 1; pipe_ra1 = 4'd2;
    #1;
    chk("sc_gnt", dbg_gnt, 1'b1);
    chk("sc_we", rf_we, 16'h0004);
    chk("sc_old", bl1, 16'h4444);
    tick();
    dbg_req = 0;
    #1;
    chk("sc_new", bl1, 16'h9999);

    // Reset while in FORCE with a starved debug read.
    tick();
    clear_inputs();
    pipe_re1 = 1; pipe_ra1 = 4'd6;
    pipe_re2 = 1; pipe_ra2 = 4'd1;
    dbg_req = 1; dbg_we = 0; dbg_addr = 4'd3;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("fr_gnt_low", dbg_gnt, 1'b0);
      chk("fr_pipe_re2", rf_re2, 16'h0002);
      tick();
    end
    chk("fr_stall", pipe_stall, 1'b1);
    chk("fr_gnt", dbg_gnt, 1'b1);
    chk("fr_re2_dbg", rf_re2, 16'h0008);
    chk("fr_re1_live", rf_re1, 16'h0040);
    #1;
    rst = 0;
    #1;
    chk("fr_rst_stall", pipe_stall, 1'b0);
    chk("fr_rst_gnt", dbg_gnt, 1'b0);
    chk("fr_rst_rvalid", dbg_rvalid, 1'b0);
    tick();
    clear_inputs();
    rst = 1;
    #1;
    chk("fr_state_idle", 32'(dut.state_q), 32'd0);
    chk("fr_cnt_zero", 32'(dut.cnt_q), 32'd0);
    chk("fr_rdata_clr", dbg_rdata, 16'h0000);
    tick();
    chk("fr_stall_after", pipe_stall, 1'b0);
    chk("fr_rvalid_after", dbg_rvalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
